// File: rtl/cndm_stat_pkg.sv
// cndm_stat_pkg: shared constants and types for the statistics accumulator.
// Stage fields are sized for the widest supported index and increment so one
// struct serves every parameterisation; the top zero-extends into them.
package cndm_stat_pkg;

    localparam int CNT_W_DEF = 64;
    localparam int IDX_W_DEF = 8;
    localparam int INC_W_DEF = 16;

    localparam int IDX_MAX_W = 16;
    localparam int INC_MAX_W = 32;

    typedef enum logic [0:0] {
        INIT = 1'b0,
        RUN  = 1'b1
    } stat_state_e;

    typedef struct packed {
        logic                 valid;
        logic                 is_read;
        logic [IDX_MAX_W-1:0] idx;
        logic [INC_MAX_W-1:0] inc;
    } stat_stage_t;

endpackage

// File: rtl/taxi_axis_if.sv
// taxi_axis_if: AXI4-Stream bundle used between the MAC statistics source and
// its consumers. KEEP_EN/LAST_EN tell a sink whether tkeep/tlast carry meaning.
interface taxi_axis_if #(
    parameter int DATA_W  = 8,
    parameter bit KEEP_EN = 1'b0,
    parameter int KEEP_W  = (DATA_W + 7) / 8,
    parameter bit LAST_EN = 1'b1,
    parameter int ID_W    = 8,
    parameter int USER_W  = 1
);
    logic [DATA_W-1:0] tdata;
    logic [KEEP_W-1:0] tkeep;
    logic              tvalid;
    logic              tready;
    logic              tlast;
    logic [ID_W-1:0]   tid;
    logic [USER_W-1:0] tuser;

    modport src (output tdata, tkeep, tvalid, tlast, tid, tuser, input tready);
    modport snk (input tdata, tkeep, tvalid, tlast, tid, tuser, output tready);
endinterface

// File: rtl/cndm_stat_ram.sv
// cndm_stat_ram: simple dual-port counter store, registered read (1 cycle).
// A read colliding with a write to the same address returns the old word;
// the accumulator forwards around that case.
module cndm_stat_ram
    import cndm_stat_pkg::*;
#(
    parameter int ADDR_W = IDX_W_DEF,
    parameter int DATA_W = CNT_W_DEF
) (
    input  logic              clk,
    input  logic [ADDR_W-1:0] rd_addr,
    output logic [DATA_W-1:0] rd_data,
    input  logic              wr_en,
    input  logic [ADDR_W-1:0] wr_addr,
    input  logic [DATA_W-1:0] wr_data
);
    logic [DATA_W-1:0] mem [2**ADDR_W];

    // Write port and registered read port, no reset on the array
    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[wr_addr] <= wr_data;
        end
        rd_data <= mem[rd_addr];
    end

endmodule

// File: rtl/cndm_stat_accum.sv
// cndm_stat_accum: accumulates MAC statistics increments into RAM-held
// counters and serves host reads, one operation per cycle.
// Build option: CNDM_STAT_ACCUM_CLEAR_ON_READ_EN makes each read zero the
// counter it returns.
//
// state | meaning
// INIT  | writing zero to every counter, stream and reads held off
// RUN   | updates and reads flow through the S0/S1/S2 pipeline
module cndm_stat_accum
    import cndm_stat_pkg::*;
#(
    parameter int CNT_W = CNT_W_DEF,
    parameter int IDX_W = IDX_W_DEF,
    parameter int INC_W = INC_W_DEF
) (
    input  logic             clk,
    input  logic             rst_n,
    taxi_axis_if.snk         s_axis_stat,
    input  logic             rd_req_valid,
    output logic             rd_req_ready,
    input  logic [IDX_W-1:0] rd_req_addr,
    output logic             rd_resp_valid,
    output logic [CNT_W-1:0] rd_resp_data,
    output logic             init_done
);

`ifdef CNDM_STAT_ACCUM_CLEAR_ON_READ_EN
    localparam bit CLEAR_ON_READ = 1'b1;
`else
    localparam bit CLEAR_ON_READ = 1'b0;
`endif

    if (s_axis_stat.DATA_W != INC_W || s_axis_stat.ID_W != IDX_W ||
        s_axis_stat.KEEP_EN || s_axis_stat.LAST_EN ||
        CNT_W < 32 || CNT_W > 64 || IDX_W > IDX_MAX_W || INC_W > INC_MAX_W) begin : g_bad_cfg
        $error("cndm_stat_accum: unsupported parameter combination");
    end

    stat_state_e      state_q;
    logic [IDX_W:0]   init_cnt_q;
    stat_stage_t      s0;
    stat_stage_t      s1_q;
    stat_stage_t      s2_q;
    logic [CNT_W-1:0] ram_rd_data;
    logic [CNT_W-1:0] s1_data;
    logic [CNT_W-1:0] s1_fwd_data_q;
    logic             s1_fwd_vld_q;
    logic [CNT_W-1:0] s2_data_q;
    logic [CNT_W-1:0] s2_result;
    logic             s2_wr_en;
    logic             s0_fwd_hit;
    logic             ram_wr_en;
    logic [IDX_W-1:0] ram_wr_addr;
    logic [CNT_W-1:0] ram_wr_data;
    logic             unused_axis;

    assign unused_axis        = ^{s_axis_stat.tkeep, s_axis_stat.tlast, s_axis_stat.tuser};
    assign s_axis_stat.tready = (state_q == RUN);
    assign rd_req_ready       = (state_q == RUN) && !s_axis_stat.tvalid;

    // S0: an update wins the slot; otherwise a pending read takes it
    always_comb begin
        s0 = '0;
        if (state_q == RUN) begin
            if (s_axis_stat.tvalid) begin
                s0.valid = 1'b1;
                s0.idx   = IDX_MAX_W'(s_axis_stat.tid);
                s0.inc   = INC_MAX_W'(s_axis_stat.tdata);
            end else if (rd_req_valid) begin
                s0.valid   = 1'b1;
                s0.is_read = 1'b1;
                s0.idx     = IDX_MAX_W'(rd_req_addr);
            end
        end
    end

    // S2: value written back this cycle; reads only write (zero) when clearing
    always_comb begin
        s2_wr_en   = s2_q.valid && (!s2_q.is_read || CLEAR_ON_READ);
        s2_result  = s2_q.is_read ? '0 : s2_data_q + CNT_W'(s2_q.inc);
        s0_fwd_hit = s2_wr_en && (s2_q.idx == s0.idx);
    end

    // S1: newest value for this index -- S2 write-back, then the write that
    // collided with our RAM read, then the RAM word itself
    always_comb begin
        if (s2_wr_en && (s2_q.idx == s1_q.idx)) begin
            s1_data = s2_result;
        end else if (s1_fwd_vld_q) begin
            s1_data = s1_fwd_data_q;
        end else begin
            s1_data = ram_rd_data;
        end
    end

    // RAM write port: clear sweep while in INIT, pipeline write-back in RUN
    always_comb begin
        if (state_q == INIT) begin
            ram_wr_en   = !init_cnt_q[IDX_W];
            ram_wr_addr = init_cnt_q[IDX_W-1:0];
            ram_wr_data = '0;
        end else begin
            ram_wr_en   = s2_wr_en;
            ram_wr_addr = s2_q.idx[IDX_W-1:0];
            ram_wr_data = s2_result;
        end
    end

    cndm_stat_ram #(
        .ADDR_W (IDX_W),
        .DATA_W (CNT_W)
    ) u_ram (
        .clk     (clk),
        .rd_addr (s0.idx[IDX_W-1:0]),
        .rd_data (ram_rd_data),
        .wr_en   (ram_wr_en),
        .wr_addr (ram_wr_addr),
        .wr_data (ram_wr_data)
    );

    // Clear sweep: one index per cycle, then one cycle to hand over to RUN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= INIT;
            init_cnt_q <= '0;
            init_done  <= 1'b0;
        end else if (state_q == INIT) begin
            if (init_cnt_q[IDX_W]) begin
                state_q   <= RUN;
                init_done <= 1'b1;
            end else begin
                init_cnt_q <= init_cnt_q + (IDX_W + 1)'(1);
            end
        end
    end

    // Pipeline advance and read response
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_q          <= '0;
            s2_q          <= '0;
            s1_fwd_vld_q  <= 1'b0;
            s1_fwd_data_q <= '0;
            s2_data_q     <= '0;
            rd_resp_valid <= 1'b0;
            rd_resp_data  <= '0;
        end else begin
            s1_q          <= s0;
            s1_fwd_vld_q  <= s0_fwd_hit;
            s1_fwd_data_q <= s2_result;
            s2_q          <= s1_q;
            s2_data_q     <= s1_data;
            rd_resp_valid <= s1_q.valid && s1_q.is_read;
            if (s1_q.valid && s1_q.is_read) begin
                rd_resp_data <= s1_data;
            end
        end
    end

endmodule
